// File: rtl/piradspi_cmd_arbiter_if.sv
// Bundle of requester-side and engine-side signals for the command arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters, the engine and any status observer together.
interface piradspi_cmd_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int CMD_WIDTH = 64
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [NUM_REQ-1:0]           req_done;
  logic [NUM_REQ-1:0]           req_error;
  logic                         m_valid;
  logic                         m_ready;
  logic [CMD_WIDTH-1:0]         m_cmd;
  logic                         cmd_completed;
  logic                         engine_error;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic                         timeout;
  logic                         stray_completion;

  modport slave (
    input  req_valid, req_cmd, m_ready, cmd_completed, engine_error,
    output req_ready, req_done, req_error, m_valid, m_cmd, grant, busy, timeout,
           stray_completion
  );

  modport master (
    output req_valid, req_cmd, m_ready, cmd_completed, engine_error,
    input  req_ready, req_done, req_error, m_valid, m_cmd, grant, busy, timeout,
           stray_completion
  );
endinterface

// File: rtl/piradspi_cmd_arbiter.sv
// Round-robin arbiter that shares the single fifo-engine command port among NUM_REQ sources.
// It holds the engine until the command completes or the watchdog expires.
module piradspi_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CMD_WIDTH      = 64,
  parameter int TIMEOUT_WIDTH  = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  piradspi_cmd_arbiter_if.slave  bus
);

  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

  state_e                   state_q;
  logic                     m_valid_q;
  logic [CMD_WIDTH-1:0]     m_cmd_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic [LG_W-1:0]          last_grant_q;
  logic [NUM_REQ-1:0]       done_q;
  logic [NUM_REQ-1:0]       error_q;
  logic                     timeout_q;
  logic                     stray_q;
  logic [TIMEOUT_WIDTH-1:0] wdog_q;

  logic                     found;
  logic [LG_W-1:0]          winner;
  logic [LG_W-1:0]          cand;
  logic [NUM_REQ-1:0]       winner_oh;

  // Scan upward from the requester after the last grant, so the most recent owner comes last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = LG_W'((int'(last_grant_q) + off) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    winner_oh = NUM_REQ'(1) << winner;
  end

  assign bus.req_ready        = (state_q == IDLE && !rst && found) ? winner_oh : '0;
  assign bus.m_valid          = m_valid_q;
  assign bus.m_cmd            = m_cmd_q;
  assign bus.grant            = grant_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.req_done         = done_q;
  assign bus.req_error        = error_q;
  assign bus.timeout          = timeout_q;
  assign bus.stray_completion = stray_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      m_valid_q    <= 1'b0;
      m_cmd_q      <= '0;
      grant_q      <= '0;
      last_grant_q <= LG_W'(NUM_REQ - 1);
      done_q       <= '0;
      error_q      <= '0;
      timeout_q    <= 1'b0;
      stray_q      <= 1'b0;
      wdog_q       <= '0;
    end else begin
      done_q    <= '0;
      error_q   <= '0;
      timeout_q <= 1'b0;
      stray_q   <= bus.cmd_completed && (state_q != WAIT_DONE);
      case (state_q)
        IDLE: begin
          if (found) begin
            m_cmd_q      <= bus.req_cmd[winner*CMD_WIDTH +: CMD_WIDTH];
            grant_q      <= winner_oh;
            last_grant_q <= winner;
            m_valid_q    <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
            wdog_q    <= '0;
            state_q   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wdog_q != '1) wdog_q <= wdog_q + 1'b1;
          // A completion arriving in the expiry cycle takes priority over the watchdog.
          if (bus.cmd_completed) begin
            done_q  <= grant_q;
            error_q <= bus.engine_error ? grant_q : '0;
            grant_q <= '0;
            state_q <= IDLE;
          end else if (WDOG_EN && wdog_q == WDOG_LAST) begin
            done_q    <= grant_q;
            error_q   <= grant_q;
            timeout_q <= 1'b1;
            grant_q   <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piradspi_cmd_arbiter.sv
// Directed testbench for piradspi_cmd_arbiter. Outputs are sampled on the falling edge,
// and inputs change there as well.
module tb_piradspi_cmd_arbiter;

  localparam int NR = 4;
  localparam int CW = 64;

  logic clk;
  logic rst;
  int testsRun;
  int testsFailed;

  piradspi_cmd_arbiter_if #(.NUM_REQ(NR), .CMD_WIDTH(CW)) bus ();

  piradspi_cmd_arbiter #(
    .NUM_REQ(NR), .CMD_WIDTH(CW), .TIMEOUT_WIDTH(20), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock with a 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    testsRun++; if (bus.grant !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_grant: got %b expected 0000", bus.grant); end
    testsRun++; if (bus.m_valid !== 1'b0 || bus.m_cmd !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_m: got valid=%b cmd=%h expected 0/0", bus.m_valid, bus.m_cmd); end
    testsRun++; if ({bus.req_ready, bus.req_done, bus.req_error} !== 12'h000) begin testsFailed++; $display("[TB] FAIL reset_req: got %h expected 000", {bus.req_ready, bus.req_done, bus.req_error}); end
    testsRun++; if ({bus.timeout, bus.stray_completion} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_pulses: got %b expected 00", {bus.timeout, bus.stray_completion}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req_cmd[1*CW +: CW] = 64'hA5;
    bus.req_valid = 4'b0010;
    bus.m_ready = 1'b1;
    #1;
    testsRun++; if (bus.req_ready !== 4'b0010) begin testsFailed++; $display("[TB] FAIL single_ready: got %b expected 0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    testsRun++; if (bus.req_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_ready_once: got %b expected 0000", bus.req_ready); end
    testsRun++; if (bus.m_valid !== 1'b1 || bus.m_cmd !== 64'hA5) begin testsFailed++; $display("[TB] FAIL single_issue: got valid=%b cmd=%h expected 1/a5", bus.m_valid, bus.m_cmd); end
    testsRun++; if (bus.grant !== 4'b0010) begin testsFailed++; $display("[TB] FAIL single_grant: got %b expected 0010", bus.grant); end
    @(negedge clk);
    testsRun++; if (bus.m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_m_valid_drop: got %b expected 0", bus.m_valid); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      testsRun++; if (bus.grant !== 4'b0010 || bus.req_done !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_hold: got grant=%b done=%b expected 0010/0000", bus.grant, bus.req_done); end
    end
    bus.cmd_completed = 1'b1;
    @(negedge clk);
    bus.cmd_completed = 1'b0;
    testsRun++; if (bus.req_done !== 4'b0010 || bus.req_error !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_done: got done=%b err=%b expected 0010/0000", bus.req_done, bus.req_error); end
    testsRun++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_release: got grant=%b busy=%b to=%b expected 0000/0/0", bus.grant, bus.busy, bus.timeout); end
    @(negedge clk);
    testsRun++; if (bus.req_done !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_done_pulse: got %b expected 0000", bus.req_done); end
  endtask

  task automatic test_stray();
    bus.cmd_completed = 1'b1;
    @(negedge clk);
    bus.cmd_completed = 1'b0;
    testsRun++; if (bus.stray_completion !== 1'b1) begin testsFailed++; $display("[TB] FAIL stray_pulse: got %b expected 1", bus.stray_completion); end
    testsRun++; if (bus.req_done !== 4'b0000 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL stray_idle: got done=%b busy=%b expected 0000/0", bus.req_done, bus.busy); end
    @(negedge clk);
    testsRun++; if (bus.stray_completion !== 1'b0 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL stray_once: got stray=%b busy=%b expected 0/0", bus.stray_completion, bus.busy); end
  endtask

  task automatic test_stall_timeout();
    bus.req_cmd[3*CW +: CW] = 64'hDEAD_BEEF_0123_4567;
    bus.req_valid = 4'b1000;
    bus.m_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    testsRun++; if (bus.grant !== 4'b1000) begin testsFailed++; $display("[TB] FAIL stall_grant: got %b expected 1000", bus.grant); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      testsRun++; if (bus.m_valid !== 1'b1 || bus.m_cmd !== 64'hDEAD_BEEF_0123_4567) begin testsFailed++; $display("[TB] FAIL stall_hold: got valid=%b cmd=%h expected 1/deadbeef01234567", bus.m_valid, bus.m_cmd); end
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    testsRun++; if (bus.m_valid !== 1'b0 || bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_handshake: got valid=%b busy=%b expected 0/1", bus.m_valid, bus.busy); end
    for (int j = 1; j < 16; j++) begin
      @(negedge clk);
      testsRun++; if (bus.req_done !== 4'b0000 || bus.timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_early: got done=%b to=%b expected 0000/0 at cycle %0d", bus.req_done, bus.timeout, j); end
    end
    @(negedge clk);
    testsRun++; if (bus.req_done !== 4'b1000 || bus.req_error !== 4'b1000) begin testsFailed++; $display("[TB] FAIL timeout_done: got done=%b err=%b expected 1000/1000", bus.req_done, bus.req_error); end
    testsRun++; if (bus.timeout !== 1'b1 || bus.grant !== 4'b0000) begin testsFailed++; $display("[TB] FAIL timeout_pulse: got to=%b grant=%b expected 1/0000", bus.timeout, bus.grant); end
    bus.req_valid = 4'b1001;
    #1;
    testsRun++; if (bus.req_ready !== 4'b0001) begin testsFailed++; $display("[TB] FAIL timeout_next_ready: got %b expected 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    testsRun++; if (bus.grant !== 4'b0001 || bus.timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_next_grant: got grant=%b to=%b expected 0001/0", bus.grant, bus.timeout); end
    @(negedge clk);
    repeat (15) @(negedge clk);
    bus.cmd_completed = 1'b1;
    bus.engine_error = 1'b0;
    @(negedge clk);
    bus.cmd_completed = 1'b0;
    testsRun++; if (bus.req_done !== 4'b0001 || bus.req_error !== 4'b0000) begin testsFailed++; $display("[TB] FAIL race_done: got done=%b err=%b expected 0001/0000", bus.req_done, bus.req_error); end
    testsRun++; if (bus.timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL race_no_timeout: got %b expected 0", bus.timeout); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 4'b0100;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    testsRun++; if (bus.busy !== 1'b1 || bus.grant !== 4'b0100) begin testsFailed++; $display("[TB] FAIL midrst_pre: got busy=%b grant=%b expected 1/0100", bus.busy, bus.grant); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    testsRun++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_state: got busy=%b grant=%b valid=%b expected 0/0000/0", bus.busy, bus.grant, bus.m_valid); end
    testsRun++; if (bus.req_done !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst_done: got %b expected 0000", bus.req_done); end
    @(negedge clk);
    testsRun++; if (bus.req_done !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst_done_after: got %b expected 0000", bus.req_done); end
    bus.req_valid = 4'b1111;
    #1;
    testsRun++; if (bus.req_ready !== 4'b0001) begin testsFailed++; $display("[TB] FAIL midrst_first_ready: got %b expected 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    testsRun++; if (bus.grant !== 4'b0001) begin testsFailed++; $display("[TB] FAIL midrst_first_grant: got %b expected 0001", bus.grant); end
  endtask

  task automatic test_round_robin();
    logic [3:0] expOh;
    logic [63:0] expCmd;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) bus.req_cmd[i*CW +: CW] = 64'h100 + 64'(i);
    bus.req_valid = 4'b1111;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      expOh = 4'b0001 << (k % 4);
      expCmd = 64'h100 + 64'(k % 4);
      #1;
      testsRun++; if (bus.req_ready !== expOh) begin testsFailed++; $display("[TB] FAIL rr_ready: got %b expected %b at %0d", bus.req_ready, expOh, k); end
      @(negedge clk);
      testsRun++; if (bus.grant !== expOh || bus.m_cmd !== expCmd || bus.m_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rr_grant: got grant=%b cmd=%h valid=%b expected %b/%h/1 at %0d", bus.grant, bus.m_cmd, bus.m_valid, expOh, expCmd, k); end
      repeat (3) @(negedge clk);
      bus.cmd_completed = 1'b1;
      bus.engine_error = (k == 2);
      @(negedge clk);
      bus.cmd_completed = 1'b0;
      bus.engine_error = 1'b0;
      testsRun++; if (bus.req_done !== expOh || bus.req_error !== ((k == 2) ? expOh : 4'b0000)) begin testsFailed++; $display("[TB] FAIL rr_done: got done=%b err=%b expected %b/%b at %0d", bus.req_done, bus.req_error, expOh, (k == 2) ? expOh : 4'b0000, k); end
    end
    bus.req_valid = 4'b0000;
    @(negedge clk);
    testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_idle: got %b expected 0", bus.busy); end
  endtask

  // Test sequence. Each task begins and ends on a falling edge.
  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_cmd = '0;
    bus.m_ready = 1'b0;
    bus.cmd_completed = 1'b0;
    bus.engine_error = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stray();
    test_stall_timeout();
    test_reset_mid();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
